// File: rtl/synth_alloc_pkg.sv
// Shared types for the voice allocator: FSM state encoding and note-on candidate classes.
// A higher class code always beats a lower one; age only breaks ties among STEAL candidates.
package synth_alloc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_e;

  typedef enum logic [1:0] {
    CLS_STEAL = 2'd0,
    CLS_REL   = 2'd1,
    CLS_IDLE  = 2'd2,
    CLS_SAME  = 2'd3
  } voice_class_e;

  function automatic voice_class_e classify(input logic gate, input logic busy, input logic note_eq);
    if (gate && note_eq) return CLS_SAME;
    else if (gate)       return CLS_STEAL;
    else if (busy)       return CLS_REL;
    else                 return CLS_IDLE;
  endfunction

endpackage

// File: rtl/voice_age_bank.sv
// Per-voice saturating age counters: on a commit strobe the chosen voice is cleared
// and every voice in inc_mask ages by one, stopping at all-ones.
module voice_age_bank #(
  parameter int C_NUM_CHAN  = 16,
  parameter int C_AGE_WIDTH = 8,
  localparam int IDX_W      = $clog2(C_NUM_CHAN)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            commit,
  input  logic [C_NUM_CHAN-1:0]           inc_mask,
  input  logic [IDX_W-1:0]                clr_idx,
  output logic [C_NUM_CHAN*C_AGE_WIDTH-1:0] ages
);

  localparam logic [C_AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [C_AGE_WIDTH-1:0] age_q [C_NUM_CHAN];

  for (genvar j = 0; j < C_NUM_CHAN; j++) begin : g_age
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age_q[j] <= '0;
      end else if (commit) begin
        if (clr_idx == IDX_W'(j))
          age_q[j] <= '0;
        else if (inc_mask[j] && (age_q[j] != AGE_MAX))
          age_q[j] <= age_q[j] + 1'b1;
      end
    end
    assign ages[C_AGE_WIDTH*(j+1)-1 : C_AGE_WIDTH*j] = age_q[j];
  end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: maps note-on/note-off events onto C_NUM_CHAN synth voices by a serial
// per-channel scan. Optional statistics counters are built when ALLOC_STATS_EN is defined.
module voice_allocator
  import synth_alloc_pkg::*;
#(
  parameter int C_NUM_CHAN   = 16,
  parameter int C_NOTE_WIDTH = 7,
  parameter int C_VEL_WIDTH  = 7,
  parameter int C_AGE_WIDTH  = 8,
  localparam int IDX_W       = $clog2(C_NUM_CHAN)
) (
  input  logic                               s_axi_aclk,
  input  logic                               s_axi_aresetn,
  input  logic                               ev_valid,
  output logic                               ev_ready,
  input  logic                               ev_note_on,
  input  logic [C_NOTE_WIDTH-1:0]            ev_note,
  input  logic [C_VEL_WIDTH-1:0]             ev_velocity,
  input  logic [C_NUM_CHAN-1:0]              voice_busy,
  output logic [C_NUM_CHAN-1:0]              gate_out,
  output logic [C_NUM_CHAN*C_NOTE_WIDTH-1:0] note_out,
  output logic [C_NUM_CHAN*C_VEL_WIDTH-1:0]  velocity_out,
  output logic [C_NUM_CHAN-1:0]              retrig_out,
  output logic [IDX_W-1:0]                   alloc_chan,
`ifdef ALLOC_STATS_EN
  input  logic                               stats_clr,
  output logic [15:0]                        steal_count,
  output logic [15:0]                        drop_count,
`endif
  output logic [1:0]                         dbg_state
);

  // Event handshake: an event is accepted on a rising edge where ev_valid && ev_ready;
  // ev_ready is registered and is high only while the FSM sits in IDLE.

  alloc_state_e state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic                    cap_on;
  logic [C_NOTE_WIDTH-1:0] cap_note;
  logic [C_VEL_WIDTH-1:0]  cap_vel;
  logic [IDX_W-1:0]        best_idx;
  voice_class_e            best_class;
  logic [C_AGE_WIDTH-1:0]  best_age;
  logic                    found;

  logic [C_NOTE_WIDTH-1:0] note_arr [C_NUM_CHAN];
  logic [C_VEL_WIDTH-1:0]  vel_arr  [C_NUM_CHAN];
  logic [C_AGE_WIDTH-1:0]  age_arr  [C_NUM_CHAN];
  logic [C_NUM_CHAN*C_AGE_WIDTH-1:0] ages;

  logic                    handshake, last_idx, take;
  logic                    cur_gate, note_eq, age_commit;
  voice_class_e            cur_class;
  logic [C_NUM_CHAN-1:0]   inc_mask;

  assign handshake  = ev_valid && ev_ready;
  assign last_idx   = (idx == IDX_W'(C_NUM_CHAN - 1));
  assign dbg_state  = state;
  assign age_commit = (state == ST_COMMIT) && cap_on;
  assign inc_mask   = gate_out & ~(C_NUM_CHAN'(1) << best_idx);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (handshake) state_nxt = ST_SCAN;
      ST_SCAN:   if (last_idx)  state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Candidate evaluation for the channel under the scan pointer.
  always_comb begin
    cur_gate  = gate_out[idx];
    note_eq   = (note_arr[idx] == cap_note);
    cur_class = classify(cur_gate, voice_busy[idx], note_eq);
    take      = 1'b0;
    if (cap_on) begin
      if (idx == '0)
        take = 1'b1;
      else if (cur_class > best_class)
        take = 1'b1;
      else if ((cur_class == CLS_STEAL) && (best_class == CLS_STEAL) && (age_arr[idx] > best_age))
        take = 1'b1;
    end else begin
      take = !found && cur_gate && note_eq;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state      <= ST_IDLE;
      ev_ready   <= 1'b0;
      idx        <= '0;
      cap_on     <= 1'b0;
      cap_note   <= '0;
      cap_vel    <= '0;
      best_idx   <= '0;
      best_class <= CLS_STEAL;
      best_age   <= '0;
      found      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ev_ready <= (state_nxt == ST_IDLE);
      if (state == ST_IDLE && handshake) begin
        idx      <= '0;
        cap_on   <= ev_note_on;
        cap_note <= ev_note;
        cap_vel  <= ev_velocity;
        found    <= 1'b0;
      end else if (state == ST_SCAN) begin
        if (!last_idx) idx <= idx + 1'b1;
        if (take) begin
          best_idx   <= idx;
          best_class <= cur_class;
          best_age   <= age_arr[idx];
          found      <= 1'b1;
        end
      end
    end
  end

  // Result registers; only the COMMIT cycle touches them.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      gate_out   <= '0;
      retrig_out <= '0;
      alloc_chan <= '0;
      for (int j = 0; j < C_NUM_CHAN; j++) begin
        note_arr[j] <= '0;
        vel_arr[j]  <= '0;
      end
    end else begin
      retrig_out <= '0;
      if (state == ST_COMMIT) begin
        if (cap_on) begin
          gate_out[best_idx]   <= 1'b1;
          note_arr[best_idx]   <= cap_note;
          vel_arr[best_idx]    <= cap_vel;
          retrig_out[best_idx] <= 1'b1;
          alloc_chan           <= best_idx;
        end else if (found) begin
          gate_out[best_idx] <= 1'b0;
          alloc_chan         <= best_idx;
        end
      end
    end
  end

  voice_age_bank #(
    .C_NUM_CHAN  (C_NUM_CHAN),
    .C_AGE_WIDTH (C_AGE_WIDTH)
  ) u_age_bank (
    .clk      (s_axi_aclk),
    .rst_n    (s_axi_aresetn),
    .commit   (age_commit),
    .inc_mask (inc_mask),
    .clr_idx  (best_idx),
    .ages     (ages)
  );

  for (genvar j = 0; j < C_NUM_CHAN; j++) begin : g_pack
    assign age_arr[j] = ages[C_AGE_WIDTH*(j+1)-1 : C_AGE_WIDTH*j];
    assign note_out[C_NOTE_WIDTH*(j+1)-1 : C_NOTE_WIDTH*j] = note_arr[j];
    assign velocity_out[C_VEL_WIDTH*(j+1)-1 : C_VEL_WIDTH*j] = vel_arr[j];
  end

`ifdef ALLOC_STATS_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      steal_count <= '0;
      drop_count  <= '0;
    end else if (stats_clr) begin
      steal_count <= '0;
      drop_count  <= '0;
    end else if (state == ST_COMMIT) begin
      if (cap_on && (best_class == CLS_STEAL) && (steal_count != 16'hFFFF))
        steal_count <= steal_count + 16'd1;
      if (!cap_on && !found && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Assigns incoming note-on/note-off events to the 16 synth channels. It drives per-channel gate, note, velocity and retrigger signals for the oscillator and envelope datapath. It sits between the MIDI/event front end and the per-channel carrier/modulator and ADSR logic configured by the AXI-lite CSR block. On note-on it allocates in strict priority order: same-note reuse, then idle voice, then releasing voice, then steal the oldest gated voice.

Parameters:
C_NUM_CHAN, 16, number of voices; must be ≥2.
C_NOTE_WIDTH, 7, note number width (MIDI).
C_VEL_WIDTH, 7, velocity width.
C_AGE_WIDTH, 8, per-voice saturating age counter width.

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
ev_valid  in  1  event valid
ev_ready  out  1  event ready
ev_note_on  in  1  1 = note-on, 0 = note-off
ev_note  in  C_NOTE_WIDTH  note number
ev_velocity  in  C_VEL_WIDTH  velocity; ignored for note-off
voice_busy  in  C_NUM_CHAN  envelope not yet finished release, per channel
gate_out  out  C_NUM_CHAN  per-channel gate
note_out  out  C_NUM_CHAN*C_NOTE_WIDTH  packed note; channel j at [W*(j+1)-1:W*j]
velocity_out  out  C_NUM_CHAN*C_VEL_WIDTH  packed velocity, same packing
retrig_out  out  C_NUM_CHAN  one-cycle pulse on each (re)assignment
alloc_chan  out  $clog2(C_NUM_CHAN)  channel chosen by the last event

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; all ages 0; FSM in IDLE. ev_ready deasserts in the reset cycle and rises on the first clock after release.
- FSM has three states: IDLE, SCAN, COMMIT.
- IDLE: ev_ready = 1. The event is captured when ev_valid & ev_ready; go to SCAN with idx = 0.
- SCAN: evaluates channel idx per cycle, idx = 0..C_NUM_CHAN-1, with ev_ready = 0. After the last idx, go to COMMIT.
- COMMIT: registers the result for one cycle, then returns to IDLE. Throughput is one event per C_NUM_CHAN+2 cycles. Outputs change on the COMMIT edge, C_NUM_CHAN+1 edges after the handshake edge.
- Note-on candidate classes, highest priority first; within a class the lowest index wins, except STEAL:
  - SAME: gate=1 and note matches.
  - IDLE: gate=0 and voice_busy=0.
  - REL: gate=0 and voice_busy=1.
  - STEAL: gate=1; pick the maximum age, ties to the lowest index.
- On note-on commit to channel c:
  - gate[c] = 1; note[c] and velocity[c] are loaded.
  - retrig_out[c] pulses for 1 cycle.
  - age[c] = 0.
  - Every other gated channel's age increments, saturating at 2^C_AGE_WIDTH-1.
- Note-off: matches the lowest-index channel with gate=1 and note equal.
  - gate[c] = 0; note and velocity are held, for the release phase.
  - No retrig pulse; ages unchanged.
  - No match: the event is dropped silently, outputs unchanged, and alloc_chan is held.
- voice_busy is sampled during SCAN at the cycle its channel is evaluated. Changes after that cycle are ignored for the current event.
- Channels never gated with voice_busy=0 count as IDLE. STEAL always succeeds, so a note-on is never dropped.
- Reset mid-SCAN aborts the event; no partial update.

Optional Feature:
Macro ALLOC_STATS_EN.
- Defined: adds outputs steal_count[15:0] and drop_count[15:0]. steal_count counts STEAL-class note-ons; drop_count counts unmatched note-offs. Both saturate at 16'hFFFF and reset to 0. Adds input stats_clr, a synchronous clear; clear wins over a simultaneous increment.
- Undefined: no ports, no counters.

Decomposition:
- Package synth_alloc_pkg: FSM state encoding (IDLE/SCAN/COMMIT) and 2-bit class codes (SAME=3, IDLE=2, REL=1, STEAL=0). Comparison is on class first, then age for STEAL.
- Sub-module voice_age_bank: holds C_NUM_CHAN saturating age counters. Inputs: inc-gated mask, clear-one index, commit strobe. Exposes ages packed.

Test Plan:
1. From reset, note-on 60 vel 100 → COMMIT after 17 edges; gate_out=16'h0001, note ch0=60, retrig_out[0] pulses 1 cycle, alloc_chan=0.
2. Note-on 60, 64, 67, then note-off 64 → gate_out=16'h0005, note ch1 still 64; a new note-on 72 with voice_busy[1]=1 goes to ch2? No: ch3 (IDLE beats REL).
3. Fill all 16 channels with notes 40..55 in order, then note-on 80 → steals ch0 (oldest, age 15), retrig_out[0] pulses, note ch0=80.
4. Note-on 60 while 60 already gated on ch5 → SAME reuse of ch5, retrig pulse, velocity updated; no other gate changes.
5. Note-off 90, not playing → outputs unchanged, ev_ready returns after 18 cycles; with ALLOC_STATS_EN, drop_count=1.
6. Assert s_axi_aresetn low at SCAN idx=7 → all outputs 0 immediately; first event after release allocates ch0.
